// File: rtl/sprite_engine_if.sv
// CPU register bus for the sprite engine.
//   enable       : chip select for reads
//   address      : register index (5 bits)
//   data_in      : write data
//   write_enable : register write strobe
//   data_out     : registered read data (driven by the engine)
interface sprite_engine_if;
  logic       enable;
  logic [4:0] address;
  logic [7:0] data_in;
  logic       write_enable;
  logic [7:0] data_out;

  modport master (output enable, address, data_in, write_enable, input data_out);
  modport slave  (input enable, address, data_in, write_enable, output data_out);
endinterface

// File: rtl/sprite_engine.sv
// Single 8x16 player sprite for the video path. Holds the sprite registers,
// fetches one bitmap row per line at HFETCH, shifts it out starting at xpos,
// and drives a registered sprite pixel/colour plus a sticky collision flag.
//   clk, reset (async, active-low)
//   bus           : register bus (slave side)
//   hpos, vpos    : current pixel / line from the HDMI timer
//   in_hblank     : horizontal blank
//   playfield_bit : playfield pixel at the same hpos
//   sprite_on     : sprite pixel visible, 1 clk after its hpos
//   sprite_color  : colour index while sprite_on, else 0
//   collision     : sticky sprite/playfield overlap, cleared by writing 0x16
//
// state | meaning
// IDLE  | no sprite on this line (disabled, off-screen, or finished)
// ARMED | row fetched, waiting for hpos == xpos
// DRAW  | shifting the row out, each bit held for width pixels
module sprite_engine #(
  parameter int HFETCH      = 0,
  parameter int LINE_REPEAT = 2,
  parameter int ROWS        = 16
) (
  input  logic           clk,
  input  logic           reset,
  sprite_engine_if.slave bus,
  input  logic [9:0]     hpos,
  input  logic [9:0]     vpos,
  input  logic           in_hblank,
  input  logic           playfield_bit,
  output logic           sprite_on,
  output logic [7:0]     sprite_color,
  output logic           collision
);
  localparam int         ROW_SHIFT = $clog2(LINE_REPEAT);
  localparam logic [9:0] SPAN      = 10'(ROWS * LINE_REPEAT);
  localparam logic [9:0] FETCH_H   = 10'(HFETCH);

  typedef enum logic [1:0] {IDLE, ARMED, DRAW} state_t;

  logic [7:0] bitmap [16];
  logic [9:0] xpos, ypos;
  logic [3:0] ctrl;
  logic [7:0] color;

  state_t     state;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic [3:0] stretch;
  logic [3:0] width_m1;

  logic [9:0] row_off;
  logic [3:0] row;
  logic [7:0] fetch_bits;
  logic [3:0] size_m1;
  logic [7:0] rd_data;
  logic       at_fetch, fetch_hit, x_hit, pix, clr_coll;

  assign row_off   = vpos - ypos;
  assign row       = row_off[ROW_SHIFT +: 4];
  assign at_fetch  = (hpos == FETCH_H);
  assign fetch_hit = ctrl[0] && (vpos >= ypos) && (row_off < SPAN);
  // The ARMED cycle that matches xpos already shows the first pixel, so the
  // registered output lands exactly one clk after the hpos it belongs to.
  assign x_hit     = (state == ARMED) && (hpos == xpos) && !at_fetch;
  assign pix       = ((state == DRAW) || x_hit) && shift[7] && !in_hblank;
  assign clr_coll  = bus.write_enable && (bus.address == 5'h16);

  always_comb begin
    fetch_bits = '0;
    for (int i = 0; i < 8; i++)
      fetch_bits[i] = ctrl[1] ? bitmap[row][7-i] : bitmap[row][i];
  end

  always_comb begin
    case (ctrl[3:2])
      2'd0:    size_m1 = 4'd1;
      2'd1:    size_m1 = 4'd3;
      2'd2:    size_m1 = 4'd7;
      default: size_m1 = 4'd15;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (!bus.address[4]) rd_data = bitmap[bus.address[3:0]];
    else begin
      case (bus.address)
        5'h10:   rd_data = xpos[7:0];
        5'h11:   rd_data = {6'b0, xpos[9:8]};
        5'h12:   rd_data = ypos[7:0];
        5'h13:   rd_data = {6'b0, ypos[9:8]};
        5'h14:   rd_data = {4'b0, ctrl};
        5'h15:   rd_data = color;
        5'h16:   rd_data = {7'b0, collision};
        default: rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) bitmap[i] <= '0;
      xpos  <= '0;
      ypos  <= '0;
      ctrl  <= '0;
      color <= '0;
    end else if (bus.write_enable) begin
      case (bus.address)
        5'h10:   xpos[7:0] <= bus.data_in;
        5'h11:   xpos[9:8] <= bus.data_in[1:0];
        5'h12:   ypos[7:0] <= bus.data_in;
        5'h13:   ypos[9:8] <= bus.data_in[1:0];
        5'h14:   ctrl      <= bus.data_in[3:0];
        5'h15:   color     <= bus.data_in;
        default: if (!bus.address[4]) bitmap[bus.address[3:0]] <= bus.data_in;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.data_out <= '0;
    else if (bus.enable && !bus.write_enable) bus.data_out <= rd_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      stretch      <= '0;
      width_m1     <= '0;
      sprite_on    <= 1'b0;
      sprite_color <= '0;
      collision    <= 1'b0;
    end else begin
      if (at_fetch) begin
        if (fetch_hit) begin
          shift <= fetch_bits;
          state <= ARMED;
        end else begin
          state <= IDLE;
        end
      end else begin
        case (state)
          ARMED: if (x_hit) begin
            state    <= DRAW;
            bit_cnt  <= '0;
            stretch  <= 4'd1;  // entry cycle already showed one pixel
            width_m1 <= size_m1;
          end
          DRAW: begin
            if (stretch == width_m1) begin
              stretch <= '0;
              shift   <= {shift[6:0], 1'b0};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) state <= IDLE;
            end else begin
              stretch <= stretch + 4'd1;
            end
          end
          default: ;
        endcase
      end

      sprite_on    <= pix;
      sprite_color <= pix ? color : 8'h00;
      // set beats a same-cycle clear
      if (pix && playfield_bit) collision <= 1'b1;
      else if (clr_coll)        collision <= 1'b0;
    end
  end
endmodule

// File: tb/tb_sprite_engine.sv
module tb_sprite_engine;
  localparam int H_TOTAL  = 800;
  localparam int H_ACTIVE = 640;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] hpos, vpos;
  logic       in_hblank, playfield_bit, sprite_on, collision;
  logic [7:0] sprite_color;

  sprite_engine_if bus();

  sprite_engine dut (
    .clk(clk), .reset(reset), .bus(bus),
    .hpos(hpos), .vpos(vpos), .in_hblank(in_hblank), .playfield_bit(playfield_bit),
    .sprite_on(sprite_on), .sprite_color(sprite_color), .collision(collision)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // register shadow
  logic [7:0] s_bmp [16];
  logic [9:0] s_x, s_y;
  logic [3:0] s_ctrl;
  logic [7:0] s_col;
  bit         m_coll;
  // per-line picture model
  bit         m_armed;
  int         m_start;
  int         m_w;
  logic [7:0] m_bits;
  bit         e_on;
  logic [7:0] e_col;
  int         on_count;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) s_bmp[i] = 8'h00;
    s_x = '0; s_y = '0; s_ctrl = '0; s_col = '0;
    m_coll = 1'b0; m_armed = 1'b0; m_start = -1; m_w = 2;
    m_bits = '0; e_on = 1'b0; e_col = '0;
  endfunction

  function automatic void shadow_write(input logic [4:0] a, input logic [7:0] d);
    if (a < 5'h10) s_bmp[a[3:0]] = d;
    else case (a)
      5'h10: s_x[7:0] = d;
      5'h11: s_x[9:8] = d[1:0];
      5'h12: s_y[7:0] = d;
      5'h13: s_y[9:8] = d[1:0];
      5'h14: s_ctrl   = d[3:0];
      5'h15: s_col    = d;
      5'h16: m_coll   = 1'b0;
      default: ;
    endcase
  endfunction

  function automatic logic [7:0] shadow_read(input logic [4:0] a);
    if (a < 5'h10) return s_bmp[a[3:0]];
    case (a)
      5'h10: return s_x[7:0];
      5'h11: return {6'b0, s_x[9:8]};
      5'h12: return s_y[7:0];
      5'h13: return {6'b0, s_y[9:8]};
      5'h14: return {4'b0, s_ctrl};
      5'h15: return s_col;
      5'h16: return {7'b0, m_coll};
      default: return 8'h00;
    endcase
  endfunction

  task automatic bus_write(input logic [4:0] a, input logic [7:0] d);
    bus.address = a; bus.data_in = d; bus.write_enable = 1'b1;
    @(posedge clk); #1;
    bus.write_enable = 1'b0;
    shadow_write(a, d);
  endtask

  task automatic bus_read(input logic [4:0] a);
    logic [7:0] exp;
    exp = shadow_read(a);
    bus.address = a; bus.enable = 1'b1; bus.write_enable = 1'b0;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    total++;
    if (bus.data_out !== exp) begin
      bad++;
      $display("FAIL read addr=%0h got=%0h want=%0h", a, bus.data_out, exp);
    end
  endtask

  // Drives hpos h_from..h_to on line vp; optional bus write at wr_h.
  // pf_mode: 0 none, 1 playfield set in [pf_lo,pf_hi], 2 random.
  task automatic run_line(input int vp, input int h_from, input int h_to,
                          input int wr_h, input logic [4:0] wa, input logic [7:0] wd,
                          input int pf_mode, input int pf_lo, input int pf_hi);
    bit pf, pix, hb;
    int off, row;
    logic [7:0] rb;
    e_on = 1'b0; e_col = '0; on_count = 0;
    for (int h = h_from; h <= h_to + 1; h++) begin
      @(posedge clk); #1;
      total++;
      if (sprite_on !== e_on) begin
        bad++;
        $display("FAIL sprite_on line=%0d hpos=%0d got=%b want=%b", vp, h - 1, sprite_on, e_on);
      end
      total++;
      if (sprite_color !== e_col) begin
        bad++;
        $display("FAIL sprite_color line=%0d hpos=%0d got=%0h want=%0h", vp, h - 1, sprite_color, e_col);
      end
      total++;
      if (collision !== m_coll) begin
        bad++;
        $display("FAIL collision line=%0d hpos=%0d got=%b want=%b", vp, h - 1, collision, m_coll);
      end
      if (sprite_on === 1'b1) on_count++;
      if (h > h_to) break;

      case (pf_mode)
        1:       pf = (h >= pf_lo) && (h <= pf_hi);
        2:       pf = 1'($urandom_range(0, 1));
        default: pf = 1'b0;
      endcase
      hb = (h >= H_ACTIVE);
      hpos = 10'(h); vpos = 10'(vp); in_hblank = hb; playfield_bit = pf;
      if (h == wr_h) begin
        bus.address = wa; bus.data_in = wd; bus.write_enable = 1'b1;
      end else begin
        bus.write_enable = 1'b0;
      end

      if (h == 0) begin
        m_start = -1;
        m_armed = 1'b0;
        if (s_ctrl[0] && vp >= int'(s_y) && (vp - int'(s_y)) < 32) begin
          row = (vp - int'(s_y)) / 2;
          rb  = s_bmp[row];
          if (s_ctrl[1]) m_bits = {<<{rb}};
          else           m_bits = rb;
          m_armed = 1'b1;
        end
      end else if (m_armed && h == int'(s_x)) begin
        m_start = h;
        m_w     = 2 << s_ctrl[3:2];
        m_armed = 1'b0;
      end
      pix = 1'b0;
      if (m_start >= 0) begin
        off = h - m_start;
        if (off < 8 * m_w) pix = m_bits[7 - off / m_w];
      end
      e_on  = pix && !hb;
      e_col = e_on ? s_col : 8'h00;
      if (h == wr_h) shadow_write(wa, wd);
      if (e_on && pf) m_coll = 1'b1;
    end
    bus.write_enable = 1'b0;
    playfield_bit = 1'b0;
  endtask

  task automatic check_count(input string tag, input int want);
    total++;
    if (on_count !== want) begin
      bad++;
      $display("FAIL %s on_count got=%0d want=%0d", tag, on_count, want);
    end
  endtask

  task automatic setup(input logic [7:0] row0, input int x, input int y,
                       input logic [3:0] ctl, input logic [7:0] col);
    bus_write(5'h00, row0);
    bus_write(5'h10, 8'(x));      bus_write(5'h11, 8'(x >> 8));
    bus_write(5'h12, 8'(y));      bus_write(5'h13, 8'(y >> 8));
    bus_write(5'h14, {4'b0, ctl}); bus_write(5'h15, col);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    hpos = 10'(H_TOTAL - 1); vpos = '0; in_hblank = 1'b1; playfield_bit = 1'b0;
    bus.enable = 1'b0; bus.write_enable = 1'b0; bus.address = '0; bus.data_in = '0;
    model_reset();
    #1;
    total++;
    if ({sprite_on, sprite_color, collision, bus.data_out} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%h%b%h want=0", sprite_on, sprite_color, collision, bus.data_out);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int a = 0; a < 32; a++) bus_read(5'(a));
    run_line(0, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 2, 0, 0);
    check_count("reset_line0", 0);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 2, 0, 0);
    check_count("reset_line50", 0);
  endtask

  task automatic test_basic();
    setup(8'h81, 100, 50, 4'h1, 8'h5A);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("basic_l50", 4);
    run_line(51, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("basic_l51", 4);
    run_line(52, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("basic_l52", 0);
  endtask

  task automatic test_reflect_size();
    bus_write(5'h00, 8'hF0);
    bus_write(5'h14, 8'h07);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("reflect_l50", 16);
  endtask

  task automatic test_collision();
    setup(8'h81, 100, 50, 4'h1, 8'h33);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 1, 100, 115);
    total++;
    if (collision !== 1'b1) begin bad++; $display("FAIL coll_set got=%b want=1", collision); end
    bus_read(5'h16);
    bus_write(5'h16, 8'h00);
    total++;
    if (collision !== 1'b0) begin bad++; $display("FAIL coll_clear got=%b want=0", collision); end
    bus_read(5'h16);
    // clear landing on the first overlap cycle loses to the set
    run_line(50, 0, H_TOTAL - 1, 100, 5'h16, 8'h00, 1, 100, 100);
    total++;
    if (collision !== 1'b1) begin bad++; $display("FAIL coll_set_wins got=%b want=1", collision); end
    bus_write(5'h16, 8'h00);
  endtask

  task automatic test_bottom_clip();
    int lines [7] = '{1020, 1021, 1022, 1023, 0, 1, 27};
    int want  [7] = '{4, 4, 8, 8, 0, 0, 0};
    setup(8'h81, 100, 1020, 4'h1, 8'h11);
    bus_write(5'h01, 8'h3C);
    bus_write(5'h02, 8'hFF);
    for (int i = 0; i < 7; i++) begin
      run_line(lines[i], 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
      check_count($sformatf("clip_l%0d", lines[i]), want[i]);
    end
    bus_write(5'h10, 8'hE8); bus_write(5'h11, 8'h03);
    run_line(1021, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("xpos_1000", 0);
  endtask

  task automatic test_midline();
    setup(8'hFF, 250, 50, 4'h1, 8'hC3);
    run_line(50, 0, H_TOTAL - 1, 100, 5'h10, 8'd120, 0, 0, 0);
    check_count("mid_xpos", 16);
    run_line(50, 0, H_TOTAL - 1, 125, 5'h00, 8'h00, 0, 0, 0);
    check_count("mid_bitmap_same", 16);
    run_line(51, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("mid_bitmap_next", 0);
    bus_write(5'h00, 8'hFF);
    run_line(50, 0, H_TOTAL - 1, 125, 5'h14, 8'h0D, 0, 0, 0);
    check_count("mid_size_same", 16);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("mid_size_next", 128);
    bus_write(5'h14, 8'h01);
    run_line(50, 0, H_TOTAL - 1, 130, 5'h14, 8'h00, 0, 0, 0);
    check_count("mid_disable_same", 16);
    run_line(51, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("mid_disable_next", 0);
  endtask

  task automatic test_random();
    int vp, x, y, wr_h;
    for (int r = 0; r < 16; r++) bus_write(5'(r), 8'($urandom));
    for (int n = 0; n < 18; n++) begin
      x = $urandom_range(1, 700);
      y = $urandom_range(0, 600);
      setup(8'($urandom), x, y, {2'($urandom), 1'($urandom), ($urandom_range(0, 4) != 0)}, 8'($urandom));
      vp = ($urandom_range(0, 3) != 0) ? y + $urandom_range(0, 40) : $urandom_range(0, 1023);
      wr_h = ($urandom_range(0, 2) == 0) ? $urandom_range(0, H_TOTAL - 1) : -1;
      run_line(vp, 0, H_TOTAL - 1, wr_h, 5'($urandom_range(0, 22)), 8'($urandom), 2, 0, 0);
      bus_read(5'($urandom_range(0, 31)));
    end
    bus_write(5'h16, 8'h00);
  endtask

  task automatic test_reset_mid_draw();
    setup(8'hFF, 100, 50, 4'h1, 8'h77);
    run_line(50, 0, 104, -1, 5'h0, 8'h0, 0, 0, 0);
    #1 reset = 1'b0;
    #1;
    total++;
    if ({sprite_on, sprite_color, collision} !== 10'h0) begin
      bad++;
      $display("FAIL async_reset got=%b/%h/%b want=0", sprite_on, sprite_color, collision);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    setup(8'hFF, 200, 50, 4'h1, 8'h77);
    run_line(50, 105, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("post_reset_idle", 0);
    run_line(50, 0, H_TOTAL - 1, -1, 5'h0, 8'h0, 0, 0, 0);
    check_count("post_reset_refetch", 16);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_reflect_size();
    test_collision();
    test_bottom_clip();
    test_midline();
    test_random();
    test_reset_mid_draw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
